mem_read_arbiter: RTL and testbench

Shares one doubleword memory read port (61-bit address, 64-bit data, combinational read) between the instruction-fetch requester and the load unit. It accepts requests with a req/gnt handshake, issues one read per cycle through a two-stage pipeline, and returns data to the owning requester with a one-cycle rvalid pulse. Loads have priority; a starvation counter guarantees fetch progress, and a fetch flush discards stale fetch data after a taken branch.

---
 rtl/mem_read_arbiter_if.sv | 36 +++
 rtl/mem_read_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_read_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_arbiter_if.sv
// Bundles the two requester ports and the memory read port of mem_read_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever surrounds it (requesters plus memory).
interface mem_read_arbiter_if #(
    parameter int ADDR_W = 61,
    parameter int DATA_W = 64
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_flush;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_rd;

    modport slave (
        input  fetch_req, fetch_addr, fetch_flush, ld_req, ld_addr, mem_data,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
               ld_gnt, ld_rvalid, ld_rdata, mem_addr, mem_rd
    );

    modport master (
        output fetch_req, fetch_addr, fetch_flush, ld_req, ld_addr, mem_data,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
               ld_gnt, ld_rvalid, ld_rdata, mem_addr, mem_rd
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Shares one combinational-read doubleword memory port between instruction
// fetch and the load unit. Loads win by default; after STARVE_MAX consecutive
// lost arbitrations fetch wins once. Two-stage pipeline: issue (mem_addr/mem_rd)
// then return (rvalid/rdata). A fetch flush kills the fetch read in stage 1.
module mem_read_arbiter #(
    parameter int ADDR_W     = 61,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               reset,
    mem_read_arbiter_if.slave  bus
);
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_LOAD  = 1'b1;

    logic              fetch_win;
    logic              ld_win;
    logic              starved;

    logic [CNT_W-1:0]  starve_cnt_d,   starve_cnt_q;
    logic [ADDR_W-1:0] mem_addr_d,     mem_addr_q;
    logic              mem_rd_d,       mem_rd_q;
    logic              owner_d,        owner_q;
    logic              fetch_rvalid_d, fetch_rvalid_q;
    logic [DATA_W-1:0] fetch_rdata_d,  fetch_rdata_q;
    logic              ld_rvalid_d,    ld_rvalid_q;
    logic [DATA_W-1:0] ld_rdata_d,     ld_rdata_q;

    // Pick at most one winner; a flush blocks fetch without handing its slot to load.
    always_comb begin
        starved   = (starve_cnt_q == STARVE_LIM);
        fetch_win = 1'b0;
        ld_win    = 1'b0;
        if (bus.ld_req && bus.fetch_req) begin
            if (starved) begin
                fetch_win = ~bus.fetch_flush;
            end else begin
                ld_win = 1'b1;
            end
        end else if (bus.ld_req) begin
            ld_win = 1'b1;
        end else if (bus.fetch_req) begin
            fetch_win = ~bus.fetch_flush;
        end else begin
            fetch_win = 1'b0;
            ld_win    = 1'b0;
        end
    end

    // Count consecutive arbitrations fetch lost to load while both were requesting.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.fetch_req || fetch_win) begin
            starve_cnt_d = '0;
        end else if (ld_win && !starved) begin
            starve_cnt_d = starve_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Issue stage: launch the winner's address; without a winner the address holds.
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        owner_d    = owner_q;
        if (ld_win) begin
            mem_addr_d = bus.ld_addr;
            mem_rd_d   = 1'b1;
            owner_d    = OWNER_LOAD;
        end else if (fetch_win) begin
            mem_addr_d = bus.fetch_addr;
            mem_rd_d   = 1'b1;
            owner_d    = OWNER_FETCH;
        end else begin
            mem_rd_d = 1'b0;
        end
    end

    // Return stage: route memory data to the owner; a flush now kills a fetch read.
    always_comb begin
        fetch_rvalid_d = 1'b0;
        fetch_rdata_d  = fetch_rdata_q;
        ld_rvalid_d    = 1'b0;
        ld_rdata_d     = ld_rdata_q;
        if (mem_rd_q) begin
            if (owner_q == OWNER_LOAD) begin
                ld_rvalid_d = 1'b1;
                ld_rdata_d  = bus.mem_data;
            end else if (!bus.fetch_flush) begin
                fetch_rvalid_d = 1'b1;
                fetch_rdata_d  = bus.mem_data;
            end else begin
                fetch_rvalid_d = 1'b0;
            end
        end else begin
            fetch_rvalid_d = 1'b0;
            ld_rvalid_d    = 1'b0;
        end
    end

    // State registers; reset drops every read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q   <= '0;
            mem_addr_q     <= '0;
            mem_rd_q       <= 1'b0;
            owner_q        <= OWNER_FETCH;
            fetch_rvalid_q <= 1'b0;
            fetch_rdata_q  <= '0;
            ld_rvalid_q    <= 1'b0;
            ld_rdata_q     <= '0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            mem_addr_q     <= mem_addr_d;
            mem_rd_q       <= mem_rd_d;
            owner_q        <= owner_d;
            fetch_rvalid_q <= fetch_rvalid_d;
            fetch_rdata_q  <= fetch_rdata_d;
            ld_rvalid_q    <= ld_rvalid_d;
            ld_rdata_q     <= ld_rdata_d;
        end
    end

    assign bus.fetch_gnt    = fetch_win;
    assign bus.ld_gnt       = ld_win;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_rd       = mem_rd_q;
    assign bus.fetch_rvalid = fetch_rvalid_q;
    assign bus.fetch_rdata  = fetch_rdata_q;
    assign bus.ld_rvalid    = ld_rvalid_q;
    assign bus.ld_rdata     = ld_rdata_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed scenarios followed by
// randomized requester traffic, checked against a cycle-indexed event model.
module tb_mem_read_arbiter;
    localparam int AW   = 61;
    localparam int DW   = 64;
    localparam int SMAX = 3;
    localparam int NC   = 1024;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory contents are a fixed scramble of the address.
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = a[31:0] ^ 32'hDEAD_BEEF;
        hi = a[60:29] + 32'h1357_9BDF;
        return {hi, lo};
    endfunction

    assign bus.mem_data = mem_fn(bus.mem_addr);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: events scheduled per cycle number.
    bit              mrd_at [NC];
    logic [AW-1:0]   maddr_at [NC];
    bit              own_ld_at [NC];
    bit              frv_at [NC];
    logic [DW-1:0]   fdat_at [NC];
    bit              lrv_at [NC];
    logic [DW-1:0]   ldat_at [NC];
    logic [AW-1:0]   cur_maddr;
    logic [DW-1:0]   cur_frd;
    logic [DW-1:0]   cur_lrd;
    int              lost;
    int              cyc;
    logic            obs_ld_gnt;

    task automatic clear_model_from(input int c);
        for (int i = c; i < NC; i++) begin
            mrd_at[i] = 1'b0; maddr_at[i] = '0; own_ld_at[i] = 1'b0;
            frv_at[i] = 1'b0; fdat_at[i] = '0;
            lrv_at[i] = 1'b0; ldat_at[i] = '0;
        end
        cur_maddr = '0; cur_frd = '0; cur_lrd = '0; lost = 0;
    endtask

    // One clock cycle: drive, predict, check mid-cycle, advance past the edge.
    task automatic run_cycle(input logic fr, input logic [AW-1:0] fa, input logic ff,
                             input logic lr, input logic [AW-1:0] la,
                             output logic eg_f, output logic eg_l);
        bus.fetch_req = fr; bus.fetch_addr = fa; bus.fetch_flush = ff;
        bus.ld_req = lr; bus.ld_addr = la;
        if (mrd_at[cyc]) cur_maddr = maddr_at[cyc];
        if (frv_at[cyc]) cur_frd = fdat_at[cyc];
        if (lrv_at[cyc]) cur_lrd = ldat_at[cyc];
        if (ff && mrd_at[cyc] && !own_ld_at[cyc]) frv_at[cyc+1] = 1'b0;
        eg_f = fr && !ff && (!lr || lost == SMAX);
        eg_l = lr && (!fr || lost != SMAX);
        if (!fr || eg_f) lost = 0;
        else if (eg_l && lost < SMAX) lost = lost + 1;
        if (eg_l || eg_f) begin
            mrd_at[cyc+1]    = 1'b1;
            maddr_at[cyc+1]  = eg_l ? la : fa;
            own_ld_at[cyc+1] = eg_l;
            if (eg_l) begin
                lrv_at[cyc+2] = 1'b1; ldat_at[cyc+2] = mem_fn(la);
            end else begin
                frv_at[cyc+2] = 1'b1; fdat_at[cyc+2] = mem_fn(fa);
            end
        end
        @(negedge clk);
        obs_ld_gnt = bus.ld_gnt;
        check_eq("fetch_gnt", 64'(bus.fetch_gnt), 64'(eg_f));
        check_eq("ld_gnt", 64'(bus.ld_gnt), 64'(eg_l));
        check_eq("mem_rd", 64'(bus.mem_rd), 64'(mrd_at[cyc]));
        check_eq("mem_addr", 64'(bus.mem_addr), 64'(cur_maddr));
        check_eq("fetch_rvalid", 64'(bus.fetch_rvalid), 64'(frv_at[cyc]));
        check_eq("ld_rvalid", 64'(bus.ld_rvalid), 64'(lrv_at[cyc]));
        check_eq("fetch_rdata", bus.fetch_rdata, cur_frd);
        check_eq("ld_rdata", bus.ld_rdata, cur_lrd);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_mem_rd"}, 64'(bus.mem_rd), 64'd0);
        check_eq({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        check_eq({tag, "_fetch_rvalid"}, 64'(bus.fetch_rvalid), 64'd0);
        check_eq({tag, "_ld_rvalid"}, 64'(bus.ld_rvalid), 64'd0);
        check_eq({tag, "_fetch_rdata"}, bus.fetch_rdata, 64'd0);
        check_eq({tag, "_ld_rdata"}, bus.ld_rdata, 64'd0);
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic do_reset();
        bus.fetch_req = 1'b0; bus.ld_req = 1'b0; bus.fetch_flush = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        clear_model_from(cyc);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
    endtask

    logic          gf, gl;
    logic [7:0]    obs_pat;
    logic [AW-1:0] fa, la;
    logic          f_pend, l_pend, ff;

    initial begin
        reset = 1'b1;
        bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.fetch_flush = 1'b0;
        bus.ld_req = 1'b0; bus.ld_addr = '0;
        cyc = 0;
        clear_model_from(0);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single fetch, then idle hold.
        run_cycle(1'b1, AW'(64'h10), 1'b0, 1'b0, '0, gf, gl);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, '0, 1'b0, 1'b0, '0, gf, gl);
        check_eq("single_fetch_data", bus.fetch_rdata, mem_fn(AW'(64'h10)));

        // Contention: both request every cycle.
        fa = AW'(64'h100); la = AW'(64'h200); obs_pat = 8'd0;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b1, fa, 1'b0, 1'b1, la, gf, gl);
            obs_pat = {obs_pat[6:0], obs_ld_gnt};
            if (gl) la = la + AW'(1);
            if (gf) fa = fa + AW'(1);
        end
        check_eq("contention_order", 64'(obs_pat), 64'(8'b1110_1110));
        for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, 1'b0, 1'b0, '0, gf, gl);

        // Flush kills the fetch read in stage 1; load in the flush cycle survives.
        run_cycle(1'b1, AW'(64'h20), 1'b0, 1'b0, '0, gf, gl);
        run_cycle(1'b1, AW'(64'h28), 1'b1, 1'b1, AW'(64'h30), gf, gl);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, 1'b0, 1'b0, '0, gf, gl);

        // Reset while a load is in flight; first contention afterwards goes to load.
        run_cycle(1'b0, '0, 1'b0, 1'b1, AW'(64'h40), gf, gl);
        do_reset();
        run_cycle(1'b1, AW'(64'h50), 1'b0, 1'b1, AW'(64'h60), gf, gl);
        check_eq("post_reset_ld_first", 64'(obs_ld_gnt), 64'd1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, 1'b0, 1'b0, '0, gf, gl);

        // Streaming loads.
        for (int i = 0; i < 4; i++) run_cycle(1'b0, '0, 1'b0, 1'b1, AW'(i), gf, gl);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, 1'b0, 1'b0, '0, gf, gl);
        check_eq("stream_last_data", bus.ld_rdata, mem_fn(AW'(64'h3)));

        // Randomized traffic with requests held until granted.
        f_pend = 1'b0; l_pend = 1'b0; fa = '0; la = '0;
        for (int i = 0; i < 700; i++) begin
            if (!f_pend && ($urandom_range(0, 2) != 0)) begin
                f_pend = 1'b1; fa = AW'({$urandom(), $urandom()});
            end
            if (!l_pend && ($urandom_range(0, 2) != 0)) begin
                l_pend = 1'b1; la = AW'({$urandom(), $urandom()});
            end
            ff = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                f_pend = 1'b0; l_pend = 1'b0;
            end else begin
                run_cycle(f_pend, fa, ff, l_pend, la, gf, gl);
                if (gf) f_pend = 1'b0;
                if (gl) l_pend = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, 1'b0, 1'b0, '0, gf, gl);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
